// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared UART state encoding and default parameters
`timescale 1ns/1ps
package uart_receiver_pkg;

   // Line-side FSM states; BREAK parks the receiver while the line is held low
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   localparam int DEFAULT_OVERSAMPLE = 16;

   // Clocks per oversample tick
   function automatic int calc_divisor(input int in_freq, input int baud, input int oversample);
      return in_freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte valid/ready handshake bundle
`timescale 1ns/1ps
interface uart_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   // Receiver side produces bytes, consumer side accepts them
   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_receiver_baud_tick.sv
// rtl/uart_receiver_baud_tick.sv - oversample tick divider shared by RX and TX
`timescale 1ns/1ps
module uart_baud_tick #(
   parameter int DIVISOR = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int            CW   = $clog2(DIVISOR) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   logic [CW-1:0] cnt_q;

   // Free-running 0..DIVISOR-1 counter; restart re-phases it to a start edge
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (restart || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8N1 UART receiver with valid/ready output
`timescale 1ns/1ps
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int IN_FREQ    = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int DATA_BITS  = 8,
   parameter int DIVISOR    = calc_divisor(IN_FREQ, BAUD, OVERSAMPLE)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            rx,
   uart_receiver_if.master rx_bus,
   output logic            frame_error,
   output logic            overrun,
   output logic            busy
);
   localparam int               SC_W     = $clog2(OVERSAMPLE);
   localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   logic                 rx_meta_q, rx_s_q;
   uart_state_e          state_q;
   logic [SC_W-1:0]      sc_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q;
   logic                 valid_q, fe_q, ovr_q;
   logic                 tick, restart, accept;

   // Two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Tick phase is aligned to the detected start edge
   assign restart = (state_q == ST_IDLE) && !rx_s_q;
   assign accept  = valid_q && rx_bus.ready;

   uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
      .clock   (clock),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // Shift register with the current data bit inserted at its LSB-first slot
   always_comb begin
      shift_d        = shift_q;
      shift_d[idx_q] = rx_s_q;
   end

   // Frame FSM plus output/handshake register; pulses default low each clock
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sc_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         fe_q  <= 1'b0;
         ovr_q <= 1'b0;
         if (accept) valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= ST_START;
                  sc_q    <= '0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (sc_q == SC_MID) begin
                     sc_q    <= '0;
                     idx_q   <= '0;
                     state_q <= rx_s_q ? ST_IDLE : ST_DATA;
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (sc_q == SC_LAST) begin
                     sc_q    <= '0;
                     shift_q <= shift_d;
                     if (idx_q == IDX_LAST) state_q <= ST_STOP;
                     else                   idx_q   <= idx_q + 1'b1;
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (sc_q == SC_LAST) begin
                     sc_q <= '0;
                     if (rx_s_q) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        // An accept in this same cycle consumes the old byte, so no overrun
                        if (valid_q && !rx_bus.ready) ovr_q <= 1'b1;
                        state_q <= ST_IDLE;
                     end else begin
                        fe_q    <= 1'b1;
                        state_q <= ST_BREAK;
                     end
                  end else begin
                     sc_q <= sc_q + 1'b1;
                  end
               end
            end
            ST_BREAK: begin
               if (rx_s_q) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx_bus.data  = data_q;
   assign rx_bus.valid = valid_q;
   assign frame_error  = fe_q;
   assign overrun      = ovr_q;
   assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;
   localparam int IN_FREQ  = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int OS       = 16;
   localparam int BIT_CLKS = IN_FREQ / BAUD;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic rx = 1'b1;
   logic frame_error, overrun, busy;
   logic ready_man = 1'b0;
   logic ready_rnd = 1'b0;
   logic rand_mode = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_ovr = 0, exp_fe = 0, ovr_seen = 0, fe_seen = 0;
   int t_rise = -1;
   logic valid_prev = 1'b0;
   logic [7:0] exp_q[$];

   uart_receiver_if #(.DATA_BITS(8)) bus ();
   assign bus.ready = rand_mode ? ready_rnd : ready_man;

   uart_receiver #(
      .IN_FREQ    (IN_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS),
      .DATA_BITS  (8)
   ) dut (
      .clock       (clk),
      .reset       (resetn),
      .rx          (rx),
      .rx_bus      (bus),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Line-level transmitter: start bit, 8 data bits LSB first, stop bit
   task automatic send_frame(input logic [7:0] b, input int per, input logic stop_v);
      rx = 1'b0;
      clks(per);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         clks(per);
      end
      rx = stop_v;
      clks(per);
   endtask

   task automatic tx_good(input logic [7:0] b, input int per);
      exp_q.push_back(b);
      send_frame(b, per, 1'b1);
   endtask

   task automatic wait_valid(input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("valid_seen", 32'(ok), 32'd1);
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (bus.valid && !valid_prev) begin
               t_rise = cyc;
               check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            end
            if (bus.valid && bus.ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL accept_unexpected: got data 0x%0h expected none", bus.data);
               end else begin
                  check("data", 32'(bus.data), 32'(exp_q.pop_front()));
               end
            end
            if (overrun) ovr_seen++;
            if (frame_error) fe_seen++;
         end
         valid_prev = bus.valid;
      end
   endtask

   task automatic rnd_ready();
      forever begin
         @(posedge clk);
         #2;
         ready_rnd = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      int t0;
      logic [7:0] b;
      fork
         monitor();
         rnd_ready();
      join_none

      // Reset state
      resetn = 1'b0;
      clks(4);
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_data", 32'(bus.data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fe", 32'(frame_error), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      resetn = 1'b1;
      clks(4);

      // Single frame, consumer always ready: one-cycle valid, latency near 9.5 bits
      ready_man = 1'b1;
      t0 = cyc;
      fork
         tx_good(8'hA5, BIT_CLKS);
         begin
            wait_valid(400);
            check("latency_in_range", 32'((t_rise - t0) >= 305 && (t_rise - t0) <= 309), 32'd1);
            @(negedge clk);
            check("valid_one_cycle", 32'(bus.valid), 32'd0);
         end
      join
      clks(20);

      // Two frames with consumer stalled: second overwrites first
      ready_man = 1'b0;
      tx_good(8'h00, BIT_CLKS);
      exp_q.pop_back();
      exp_ovr++;
      tx_good(8'hFF, BIT_CLKS);
      clks(10);
      check("held_valid", 32'(bus.valid), 32'd1);
      check("held_data", 32'(bus.data), 32'hFF);
      check("overrun_once", 32'(ovr_seen), 32'(exp_ovr));
      ready_man = 1'b1;
      clks(1);
      check("valid_after_accept", 32'(bus.valid), 32'd0);
      clks(10);

      // Short low glitch: no frame
      rx = 1'b0;
      clks(6);
      rx = 1'b1;
      clks(3);
      check("glitch_busy", 32'(busy), 32'd1);
      clks(40);
      check("glitch_idle", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(bus.valid), 32'd0);

      // Bad stop bit followed by held-low line
      send_frame(8'h3C, BIT_CLKS, 1'b0);
      exp_fe++;
      clks(100);
      check("fe_count", 32'(fe_seen), 32'(exp_fe));
      check("break_busy", 32'(busy), 32'd1);
      check("break_no_valid", 32'(bus.valid), 32'd0);
      rx = 1'b1;
      clks(10);
      check("break_released", 32'(busy), 32'd0);
      tx_good(8'h81, BIT_CLKS);
      clks(20);

      // Reset during data bit 4 of 0x5A
      b = 8'h5A;
      rx = 1'b0;
      clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         clks(BIT_CLKS);
      end
      rx = b[4];
      clks(BIT_CLKS / 2);
      check("pre_reset_busy", 32'(busy), 32'd1);
      resetn = 1'b0;
      clks(1);
      resetn = 1'b1;
      rx = 1'b1;
      check("mid_rst_valid", 32'(bus.valid), 32'd0);
      check("mid_rst_data", 32'(bus.data), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_fe", 32'(frame_error), 32'd0);
      check("mid_rst_ovr", 32'(overrun), 32'd0);
      clks(50);
      tx_good(8'h5A, BIT_CLKS);
      clks(20);

      // Baud skew on the transmitter
      tx_good(8'h96, BIT_CLKS - 1);
      clks(40);
      tx_good(8'h96, BIT_CLKS + 1);
      clks(40);

      // Random bytes, random skew, random consumer stalls
      rand_mode = 1'b1;
      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom_range(0, 255));
         tx_good(b, $urandom_range(BIT_CLKS - 1, BIT_CLKS + 1));
         clks($urandom_range(0, 20));
      end
      clks(40);
      rand_mode = 1'b0;
      ready_man = 1'b1;
      clks(10);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));
      check("fe_total", 32'(fe_seen), 32'(exp_fe));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
